// File: rtl/pipe_pkg.sv
// Shared defaults and FSM encoding for the block-throttled pipe-out source.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DATA_W_DEF, ADDR_W_DEF, BLOCK_WORDS_DEF - parameter defaults for the top
//   state_t                                 - block FSM states
package pipe_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 10;
    localparam int BLOCK_WORDS_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_fifo_sdp.sv
// Simple dual-port word store: one write port, one registered read port.
// Latency: read data appears the cycle after rd_en and holds until the next rd_en.
// Backpressure: none; the caller owns pointers and full/empty decisions.
//
// Ports:
//   clk              clock for both ports
//   wr_en/addr/data  synchronous write
//   rd_en/addr       read request; rd_data is registered
//   rd_data          last word read
module pipe_fifo_sdp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pipe_out_block_source.sv
// Buffers user words and releases them to the host pipe-out endpoint in whole blocks.
// Latency: data valid 1 cycle after pipe_out_read; ready rises 1 cycle after a block is buffered.
// Backpressure: src_ready = !full (from registered counters); a write at full is refused even on a read.
//
// Ports:
//   clk, reset                 okClk and async active-high reset
//   src_valid/src_data/src_ready   user push interface
//   pipe_out_read/_data/_ready     endpoint interface (one strobe per word)
//   level                      words buffered
//   underflow                  sticky flag: read while empty
//   words_sent, blocks_sent    wrapping 32-bit delivery counters
module pipe_out_block_source
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              pipe_out_read,
    output logic [DATA_W-1:0] pipe_out_data,
    output logic              pipe_out_ready,
    output logic [ADDR_W:0]   level,
    output logic              underflow,
    output logic [31:0]       words_sent,
    output logic [31:0]       blocks_sent
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int LVL_W  = ADDR_W + 1;
    localparam int BEAT_W = $clog2(BLOCK_WORDS) + 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_BLOCK = LVL_W'(BLOCK_WORDS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);

    // Free-running word counters one bit wider than the address; their
    // difference is the fill level and their low bits are the RAM pointers.
    logic [LVL_W-1:0] wr_cnt;
    logic [LVL_W-1:0] rd_cnt;
    logic [LVL_W-1:0] wr_cnt_next;
    logic [LVL_W-1:0] rd_cnt_next;
    logic [LVL_W-1:0] level_next;

    logic             full;
    logic             push;
    logic             pop;
    logic             data_zero;
    logic [DATA_W-1:0] ram_q;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;

    assign level     = wr_cnt - rd_cnt;
    assign full      = (level == LVL_FULL);
    assign src_ready = !full;

    assign push = src_valid && !full;
    assign pop  = pipe_out_read && (level != '0);

    assign wr_cnt_next = wr_cnt + LVL_W'(push);
    assign rd_cnt_next = rd_cnt + LVL_W'(pop);
    assign level_next  = wr_cnt_next - rd_cnt_next;

    pipe_fifo_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (src_data),
        .rd_en   (pop),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    // The RAM read register has no reset, so a registered zero flag forces the
    // output to 0 after reset and after an empty read.
    assign pipe_out_data  = data_zero ? '0 : ram_q;
    assign pipe_out_ready = (state == ARMED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            data_zero  <= 1'b1;
            underflow  <= 1'b0;
            words_sent <= '0;
        end else begin
            wr_cnt <= wr_cnt_next;
            rd_cnt <= rd_cnt_next;
            if (pipe_out_read) begin
                words_sent <= words_sent + 32'd1;
                data_zero  <= !pop;
                if (!pop) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    // Block FSM. Arming uses the registered level (one-cycle lag); the end of a
    // block re-arms from the level after that edge so back-to-back blocks flow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            blocks_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level >= LVL_BLOCK) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (pipe_out_read) begin
                        if (BLOCK_WORDS == 1) begin
                            blocks_sent <= blocks_sent + 32'd1;
                            state       <= (level_next >= LVL_BLOCK) ? ARMED : IDLE;
                        end else begin
                            beat_cnt <= BEAT_W'(1);
                            state    <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (pipe_out_read) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == BEAT_LAST) begin
                            blocks_sent <= blocks_sent + 32'd1;
                            state       <= (level_next >= LVL_BLOCK) ? ARMED : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_out_block_source.sv
// Bench for pipe_out_block_source: queue-based reference model compared every cycle,
// plus directed literal expectations at the points of interest.
// Inputs change 1 ns after the rising edge; outputs are compared on the falling edge.
module tb_pipe_out_block_source;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BW    = 256;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          pipe_out_read;
    logic [DW-1:0] pipe_out_data;
    logic          pipe_out_ready;
    logic [AW:0]   level;
    logic          underflow;
    logic [31:0]   words_sent;
    logic [31:0]   blocks_sent;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_out_block_source #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_ready (pipe_out_ready),
        .level          (level),
        .underflow      (underflow),
        .words_sent     (words_sent),
        .blocks_sent    (blocks_sent)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Buffer is a plain queue; "ready" is a flag that the host sees a full block,
    // and beats counts reads taken from the current block.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data     = '0;
    bit            m_under    = 1'b0;
    bit            m_ready    = 1'b0;
    bit            m_in_block = 1'b0;
    int            m_beats    = 0;
    logic [31:0]   m_ws       = '0;
    logic [31:0]   m_bs       = '0;

    always @(posedge clk or posedge reset) begin
        int  lvl_before;
        bit  take_word;
        bit  block_done;
        if (reset) begin
            mq.delete();
            m_data     = '0;
            m_under    = 1'b0;
            m_ready    = 1'b0;
            m_in_block = 1'b0;
            m_beats    = 0;
            m_ws       = '0;
            m_bs       = '0;
        end else begin
            lvl_before = mq.size();
            take_word  = src_valid && (lvl_before != DEPTH);
            block_done = 1'b0;
            if (pipe_out_read) begin
                m_ws = m_ws + 1;
                if (lvl_before != 0) begin
                    m_data = mq.pop_front();
                end else begin
                    m_data  = '0;
                    m_under = 1'b1;
                end
            end
            if (take_word) mq.push_back(src_data);

            if (m_ready) begin
                if (pipe_out_read) begin
                    m_ready    = 1'b0;
                    m_in_block = 1'b1;
                    m_beats    = 1;
                    block_done = (m_beats == BW);
                end
            end else if (m_in_block) begin
                if (pipe_out_read) begin
                    m_beats++;
                    block_done = (m_beats == BW);
                end
            end else if (lvl_before >= BW) begin
                m_ready = 1'b1;
            end

            if (block_done) begin
                m_bs       = m_bs + 1;
                m_in_block = 1'b0;
                m_ready    = (mq.size() >= BW);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_src_ready", src_ready, mq.size() != DEPTH);
        chk("m_ready", pipe_out_ready, m_ready);
        chk("m_level", level, mq.size());
        chk("m_underflow", underflow, m_under);
        chk("m_words_sent", words_sent, m_ws);
        chk("m_blocks_sent", blocks_sent, m_bs);
        chk("m_data", pipe_out_data, m_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_data  = base + DW'(i);
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
    endtask

    task automatic read_n(input int n, input bit lit, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            pipe_out_read = 1'b1;
            @(posedge clk); #1;
            if (lit) chk("blk_data", pipe_out_data, base + DW'(i));
        end
        pipe_out_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic mid_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_level", level, 0);
        chk("rst_src_ready", src_ready, 1);
        chk("rst_ready", pipe_out_ready, 0);
        chk("rst_data", pipe_out_data, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_words", words_sent, 0);
        chk("rst_blocks", blocks_sent, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        src_valid     = 1'b0;
        src_data      = '0;
        pipe_out_read = 1'b0;
        idle(3);
        reset = 1'b0;
        chk("init_src_ready", src_ready, 1);
        chk("init_ready", pipe_out_ready, 0);
        chk("init_level", level, 0);

        // One word short of a block keeps ready low; the 256th arms it a cycle later.
        push_n(255, 0);
        idle(2);
        chk("t2_ready_255", pipe_out_ready, 0);
        push_n(1, 255);
        chk("t2_ready_lag", pipe_out_ready, 0);
        idle(1);
        chk("t2_ready_256", pipe_out_ready, 1);
        read_n(BW, 1'b1, 0);
        chk("t2_blocks", blocks_sent, 1);
        chk("t2_ready_after", pipe_out_ready, 0);
        chk("t2_level", level, 0);

        // Fill to full; a simultaneous push and read at full refuses the push.
        push_n(DEPTH, 1000);
        chk("t3_full_src_ready", src_ready, 0);
        chk("t3_full_level", level, 1024);
        src_valid     = 1'b1;
        src_data      = 32'd5555;
        pipe_out_read = 1'b1;
        @(posedge clk); #1;
        src_valid     = 1'b0;
        pipe_out_read = 1'b0;
        chk("t3_level_1023", level, 1023);
        chk("t3_data", pipe_out_data, 1000);
        chk("t3_src_ready", src_ready, 1);

        mid_reset();

        // Back-to-back blocks from a 600-word preload.
        push_n(600, 0);
        idle(1);
        chk("t4_ready", pipe_out_ready, 1);
        read_n(BW, 1'b1, 0);
        chk("t4_rearm", pipe_out_ready, 1);
        chk("t4_level1", level, 344);
        read_n(BW, 1'b1, 256);
        chk("t4_level2", level, 88);
        chk("t4_ready2", pipe_out_ready, 0);
        chk("t4_blocks", blocks_sent, 2);
        idle(2);
        chk("t4_ready_hold", pipe_out_ready, 0);

        // Drain the tail in IDLE, then read empty.
        read_n(88, 1'b1, 512);
        chk("t5_ws_before", words_sent, 600);
        read_n(1, 1'b0, 0);
        chk("t5_data", pipe_out_data, 0);
        chk("t5_underflow", underflow, 1);
        chk("t5_ws", words_sent, 601);
        chk("t5_level", level, 0);
        idle(3);
        chk("t5_sticky", underflow, 1);

        // Reset in the middle of a block, then a clean block.
        push_n(BW, 7000);
        idle(1);
        read_n(100, 1'b1, 7000);
        chk("t6_blocks_pre", blocks_sent, 2);
        mid_reset();
        push_n(BW, 0);
        idle(1);
        chk("t6_ready", pipe_out_ready, 1);
        read_n(BW, 1'b1, 0);
        chk("t6_blocks", blocks_sent, 1);
        chk("t6_level", level, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
